// File: rtl/control_seq_hs.sv
// control_seq_hs: negedge-updating microsequencer for the 8-bit bus CPU.
// Walks FETCH0 -> FETCH1 -> EXEC (steps 2..4) per instruction and drives every
// datapath load strobe, the bus selector and the ALU op. The MRS instruction
// runs a start/done handshake with the peripheral under a watchdog. HLT is sticky
// until reset. Unknown opcodes are flagged and then skipped like a NOP.
//
// Ports
//   clock, bReset            : clock (sequencer acts on negedge) / async active-high reset
//   instruction              : opcode from the instruction register
//   carry_flag, zero_flag    : registered ALU flags used by JC / JZ
//   periph_busy, periph_done : peripheral handshake inputs
//   hlt                      : sticky halt
//   memory_in .. flags_in    : datapath load strobes
//   alu_op, bus_selector     : ALU function and bus source select
//   periph_start             : one-cycle start pulse to the peripheral
//   step                     : current microstep (saturating)
//   illegal_op, timeout_err  : sticky error flags
module control_seq_hs #(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 5,
  parameter int TIMEOUT  = 32
) (
  input  logic                clock,
  input  logic                bReset,
  input  logic [OPCODE_W-1:0] instruction,
  input  logic                carry_flag,
  input  logic                zero_flag,
  input  logic                periph_busy,
  input  logic                periph_done,
  output logic                hlt,
  output logic                memory_in,
  output logic                ram_in,
  output logic                instruction_in,
  output logic                reg_a_in,
  output logic                reg_b_in,
  output logic                out_in,
  output logic                advance_pc,
  output logic                pc_in,
  output logic                flags_in,
  output logic [1:0]          alu_op,
  output logic [3:0]          bus_selector,
  output logic                periph_start,
  output logic [STEP_W-1:0]   step,
  output logic                illegal_op,
  output logic                timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] BUS_NONE = 4'd0;
  localparam logic [3:0] BUS_PC   = 4'd1;
  localparam logic [3:0] BUS_REGA = 4'd2;
  localparam logic [3:0] BUS_ALU  = 4'd3;
  localparam logic [3:0] BUS_MEM  = 4'd5;
  localparam logic [3:0] BUS_IR   = 4'd6;

  // state_q names the step that the NEXT negedge will execute.
  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    EXEC   = 3'd2,
    STALL  = 3'd3,
    WAIT   = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef struct packed {
    logic              hlt;
    logic              mem;
    logic              ram;
    logic              ir;
    logic              ra;
    logic              rb;
    logic              out;
    logic              apc;
    logic              pc;
    logic              fl;
    logic [1:0]        alu;
    logic [3:0]        bus;
    logic              start;
    logic [STEP_W-1:0] step;
    logic              ill;
    logic              tmo;
  } outs_t;

  state_t            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d, wd_inc_s;
  logic              wd_exp_s;
  logic              op_hi_bad_s;
  logic [3:0]        op_lo_s;
  outs_t             outs_q, outs_d;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    if (v == {STEP_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + STEP_W'(1);
    end
  endfunction

  assign op_lo_s     = instruction[3:0];
  assign op_hi_bad_s = (instruction >> 4) != {OPCODE_W{1'b0}};
  assign wd_inc_s    = wd_q + WD_W'(1);
  // This negedge is the TIMEOUT-th one spent stalled/waiting.
  assign wd_exp_s    = (wd_inc_s >= WD_W'(TIMEOUT));

  // Next-state and next-output decode for the coming negedge.
  always_comb begin
    state_d     = state_q;
    wd_d        = {WD_W{1'b0}};
    outs_d      = '0;
    outs_d.ill  = outs_q.ill;
    outs_d.tmo  = outs_q.tmo;
    outs_d.step = cnt_q;
    case (state_q)
      FETCH0: begin
        outs_d.bus = BUS_PC;
        outs_d.mem = 1'b1;
        state_d    = FETCH1;
      end
      FETCH1: begin
        outs_d.bus = BUS_MEM;
        outs_d.ir  = 1'b1;
        outs_d.apc = 1'b1;
        state_d    = EXEC;
      end
      EXEC: begin
        state_d = FETCH0;
        if (op_hi_bad_s) begin
          outs_d.ill = 1'b1;
        end else begin
          case (op_lo_s)
            4'h0: ;
            4'h1: begin
              if (cnt_q == STEP_W'(2)) begin
                outs_d.bus = BUS_IR; outs_d.mem = 1'b1; state_d = EXEC;
              end else begin
                outs_d.bus = BUS_MEM; outs_d.ra = 1'b1;
              end
            end
            4'h2, 4'h3: begin
              if (cnt_q == STEP_W'(2)) begin
                outs_d.bus = BUS_IR; outs_d.mem = 1'b1; state_d = EXEC;
              end else if (cnt_q == STEP_W'(3)) begin
                outs_d.bus = BUS_MEM; outs_d.rb = 1'b1; outs_d.fl = 1'b1; state_d = EXEC;
              end else begin
                outs_d.bus = BUS_ALU; outs_d.ra = 1'b1;
                outs_d.alu = (op_lo_s == 4'h3) ? 2'b01 : 2'b00;
              end
            end
            4'h4: begin
              if (cnt_q == STEP_W'(2)) begin
                outs_d.bus = BUS_IR; outs_d.mem = 1'b1; state_d = EXEC;
              end else begin
                outs_d.bus = BUS_REGA; outs_d.ram = 1'b1;
              end
            end
            4'h5: begin outs_d.bus = BUS_IR; outs_d.ra = 1'b1; end
            4'h6: begin outs_d.bus = BUS_IR; outs_d.pc = 1'b1; end
            4'h7, 4'h8: begin
              // Not-taken branch emits no strobes but still ends the instruction.
              if ((op_lo_s == 4'h7) ? carry_flag : zero_flag) begin
                outs_d.bus = BUS_IR; outs_d.pc = 1'b1;
              end else begin
                outs_d.bus = BUS_NONE;
              end
            end
            4'h9, 4'hA: begin
              if (cnt_q == STEP_W'(2)) begin
                outs_d.bus = BUS_IR; outs_d.mem = 1'b1; state_d = EXEC;
              end else begin
                outs_d.bus = BUS_ALU; outs_d.ra = 1'b1; outs_d.fl = 1'b1;
                outs_d.alu = (op_lo_s == 4'h9) ? 2'b10 : 2'b11;
              end
            end
            4'hB: begin outs_d.bus = BUS_IR; outs_d.mem = 1'b1; state_d = STALL; end
            4'hE: begin outs_d.bus = BUS_REGA; outs_d.out = 1'b1; end
            4'hF: begin outs_d.hlt = 1'b1; state_d = HALT; end
            default: outs_d.ill = 1'b1;
          endcase
        end
      end
      STALL: begin
        wd_d = wd_inc_s;
        // Expiry aborts the op before any start pulse is issued.
        if (wd_exp_s) begin
          outs_d.tmo = 1'b1; state_d = FETCH0;
        end else if (!periph_busy) begin
          outs_d.start = 1'b1; state_d = WAIT;
        end else begin
          state_d = STALL;
        end
      end
      WAIT: begin
        wd_d = wd_inc_s;
        // done beats a simultaneous watchdog expiry.
        if (periph_done) begin
          state_d = FETCH0;
        end else if (wd_exp_s) begin
          outs_d.tmo = 1'b1; state_d = FETCH0;
        end else begin
          state_d = WAIT;
        end
      end
      HALT: begin
        outs_d.hlt = 1'b1;
        state_d    = HALT;
      end
      default: state_d = FETCH0;
    endcase
    if (state_d == FETCH0) begin
      cnt_d = {STEP_W{1'b0}};
    end else begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Sequencer state and registered outputs, updated on the falling edge.
  always_ff @(negedge clock or posedge bReset) begin
    if (bReset) begin
      state_q <= FETCH0;
      cnt_q   <= {STEP_W{1'b0}};
      wd_q    <= {WD_W{1'b0}};
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
      outs_q  <= outs_d;
    end
  end

  assign hlt            = outs_q.hlt;
  assign memory_in      = outs_q.mem;
  assign ram_in         = outs_q.ram;
  assign instruction_in = outs_q.ir;
  assign reg_a_in       = outs_q.ra;
  assign reg_b_in       = outs_q.rb;
  assign out_in         = outs_q.out;
  assign advance_pc     = outs_q.apc;
  assign pc_in          = outs_q.pc;
  assign flags_in       = outs_q.fl;
  assign alu_op         = outs_q.alu;
  assign bus_selector   = outs_q.bus;
  assign periph_start   = outs_q.start;
  assign step           = outs_q.step;
  assign illegal_op     = outs_q.ill;
  assign timeout_err    = outs_q.tmo;

endmodule

// File: tb/tb_control_seq_hs.sv
// Self-checking bench for control_seq_hs: table of per-instruction microstep
// expectations, directed handshake/halt/reset sequences, and randomized
// instructions checked against an ISA-level reference model.
module tb_control_seq_hs;

  localparam int TIMEOUT = 32;

  localparam logic [8:0] S_MEM = 9'h100;
  localparam logic [8:0] S_RAM = 9'h080;
  localparam logic [8:0] S_IR  = 9'h040;
  localparam logic [8:0] S_RA  = 9'h020;
  localparam logic [8:0] S_RB  = 9'h010;
  localparam logic [8:0] S_OUT = 9'h008;
  localparam logic [8:0] S_APC = 9'h004;
  localparam logic [8:0] S_PC  = 9'h002;
  localparam logic [8:0] S_FL  = 9'h001;

  typedef struct packed {
    logic       hlt;
    logic       ill;
    logic       tmo;
    logic       start;
    logic [4:0] step;
    logic [3:0] bus;
    logic [1:0] alu;
    logic [8:0] strb;
  } obs_t;

  typedef struct {
    logic [3:0]  op;
    bit          c;
    bit          z;
    int          n;
    logic [14:0] s0, s1, s2;
  } vec_t;

  logic clock = 1'b1;
  always #5 clock = ~clock;

  logic       bReset = 1'b1;
  logic [3:0] instruction = 4'h0;
  logic [5:0] instr6 = 6'h00;
  logic carry_flag = 1'b0, zero_flag = 1'b0, periph_busy = 1'b0, periph_done = 1'b0;

  logic hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, out_in;
  logic advance_pc, pc_in, flags_in, periph_start, illegal_op, timeout_err;
  logic [1:0] alu_op;
  logic [3:0] bus_selector;
  logic [4:0] step;

  logic d6_hlt, d6_mem, d6_ram, d6_ir, d6_ra, d6_rb, d6_out;
  logic d6_apc, d6_pc, d6_fl, d6_start, d6_ill, d6_tmo;
  logic [1:0] d6_alu;
  logic [3:0] d6_bus;
  logic [4:0] d6_step;

  control_seq_hs #(.OPCODE_W(4), .STEP_W(5), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .bReset(bReset), .instruction(instruction),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .periph_busy(periph_busy), .periph_done(periph_done),
    .hlt(hlt), .memory_in(memory_in), .ram_in(ram_in), .instruction_in(instruction_in),
    .reg_a_in(reg_a_in), .reg_b_in(reg_b_in), .out_in(out_in), .advance_pc(advance_pc),
    .pc_in(pc_in), .flags_in(flags_in), .alu_op(alu_op), .bus_selector(bus_selector),
    .periph_start(periph_start), .step(step), .illegal_op(illegal_op),
    .timeout_err(timeout_err)
  );

  control_seq_hs #(.OPCODE_W(6), .STEP_W(5), .TIMEOUT(TIMEOUT)) dut6 (
    .clock(clock), .bReset(bReset), .instruction(instr6),
    .carry_flag(1'b0), .zero_flag(1'b0),
    .periph_busy(1'b0), .periph_done(1'b0),
    .hlt(d6_hlt), .memory_in(d6_mem), .ram_in(d6_ram), .instruction_in(d6_ir),
    .reg_a_in(d6_ra), .reg_b_in(d6_rb), .out_in(d6_out), .advance_pc(d6_apc),
    .pc_in(d6_pc), .flags_in(d6_fl), .alu_op(d6_alu), .bus_selector(d6_bus),
    .periph_start(d6_start), .step(d6_step), .illegal_op(d6_ill),
    .timeout_err(d6_tmo)
  );

  int   checks = 0;
  int   errors = 0;
  logic ill_exp = 1'b0;
  logic tmo_exp = 1'b0;
  vec_t vt[15];

  function automatic obs_t get_obs();
    obs_t o;
    o.hlt = hlt; o.ill = illegal_op; o.tmo = timeout_err; o.start = periph_start;
    o.step = step; o.bus = bus_selector; o.alu = alu_op;
    o.strb = {memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, out_in,
              advance_pc, pc_in, flags_in};
    return o;
  endfunction

  function automatic obs_t get_obs6();
    obs_t o;
    o.hlt = d6_hlt; o.ill = d6_ill; o.tmo = d6_tmo; o.start = d6_start;
    o.step = d6_step; o.bus = d6_bus; o.alu = d6_alu;
    o.strb = {d6_mem, d6_ram, d6_ir, d6_ra, d6_rb, d6_out, d6_apc, d6_pc, d6_fl};
    return o;
  endfunction

  function automatic logic [14:0] ms(input logic [3:0] b, input logic [1:0] a, input logic [8:0] s);
    return {b, a, s};
  endfunction

  function automatic obs_t mk(input logic h, input logic il, input logic tm, input logic st,
                              input int stp, input logic [14:0] sv);
    obs_t o;
    o.hlt = h; o.ill = il; o.tmo = tm; o.start = st;
    o.step = (stp > 31) ? 5'd31 : 5'(stp);
    o.bus = sv[14:11]; o.alu = sv[10:9]; o.strb = sv[8:0];
    return o;
  endfunction

  function automatic obs_t eo(input int stp, input logic [14:0] sv, input logic st, input logic h);
    return mk(h, ill_exp, tmo_exp, st, stp, sv);
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input bit c, input bit z, input int n,
                               input logic [14:0] s0, input logic [14:0] s1, input logic [14:0] s2);
    vec_t v;
    v.op = op; v.c = c; v.z = z; v.n = n; v.s0 = s0; v.s1 = s1; v.s2 = s2;
    return v;
  endfunction

  task automatic chk(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  // Called two time units after a negedge; reset is asserted away from any edge.
  task automatic do_reset();
    bReset = 1'b1;
    ill_exp = 1'b0;
    tmo_exp = 1'b0;
    #1;
    chk("reset", get_obs(), eo(0, 15'h0, 1'b0, 1'b0));
    #1;
    bReset = 1'b0;
  endtask

  // ISA-level model: the microstep transfers each instruction performs.
  task automatic model(input logic [3:0] op, input bit c, input bit z, output int n,
                       output logic [14:0] s0, output logic [14:0] s1, output logic [14:0] s2);
    logic [14:0] addr;
    addr = ms(4'd6, 2'd0, S_MEM);  // operand address from IR into MAR
    s0 = 15'h0; s1 = 15'h0; s2 = 15'h0; n = 1;
    case (op)
      4'h1: begin n = 2; s0 = addr; s1 = ms(4'd5, 2'd0, S_RA); end
      4'h2, 4'h3: begin
        n = 3; s0 = addr; s1 = ms(4'd5, 2'd0, S_RB | S_FL);
        s2 = ms(4'd3, (op == 4'h3) ? 2'd1 : 2'd0, S_RA);
      end
      4'h4: begin n = 2; s0 = addr; s1 = ms(4'd2, 2'd0, S_RAM); end
      4'h5: s0 = ms(4'd6, 2'd0, S_RA);
      4'h6: s0 = ms(4'd6, 2'd0, S_PC);
      4'h7: s0 = c ? ms(4'd6, 2'd0, S_PC) : 15'h0;
      4'h8: s0 = z ? ms(4'd6, 2'd0, S_PC) : 15'h0;
      4'h9, 4'hA: begin
        n = 2; s0 = addr; s1 = ms(4'd3, (op == 4'h9) ? 2'd2 : 2'd3, S_RA | S_FL);
      end
      4'hE: s0 = ms(4'd2, 2'd0, S_OUT);
      default: s0 = 15'h0;
    endcase
  endtask

  task automatic run_fetch(input string name);
    tick();
    chk({name, ".f0"}, get_obs(), eo(0, ms(4'd1, 2'd0, S_MEM), 1'b0, 1'b0));
    tick();
    chk({name, ".f1"}, get_obs(), eo(1, ms(4'd5, 2'd0, S_IR | S_APC), 1'b0, 1'b0));
  endtask

  task automatic run_op(input logic [3:0] op, input bit c, input bit z, input int n,
                        input logic [14:0] s0, input logic [14:0] s1, input logic [14:0] s2,
                        input string name);
    logic [14:0] sv [3];
    sv[0] = s0; sv[1] = s1; sv[2] = s2;
    instruction = op; carry_flag = c; zero_flag = z;
    periph_busy = 1'($urandom_range(0, 1));
    periph_done = 1'($urandom_range(0, 1));
    run_fetch(name);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i == 0 && (op == 4'hC || op == 4'hD)) ill_exp = 1'b1;
      chk($sformatf("%s.s%0d", name, i + 2), get_obs(), eo(2 + i, sv[i], 1'b0, 1'b0));
    end
  endtask

  // b: negedges with busy held; d: WAIT negedge on which done is pulsed (0 = never).
  task automatic run_mrs(input int b, input int d, input string name);
    logic st, fin;
    instruction = 4'hB;
    periph_busy = 1'b0; periph_done = 1'b0;
    run_fetch(name);
    tick();
    chk({name, ".s2"}, get_obs(), eo(2, ms(4'd6, 2'd0, S_MEM), 1'b0, 1'b0));
    for (int k = 1; k <= TIMEOUT; k++) begin
      periph_busy = (k <= b);
      periph_done = (k <= b) ? (k == 1) : (d != 0 && k == b + 1 + d);
      tick();
      st = 1'b0; fin = 1'b0;
      if (k <= b + 1) begin
        if (k == TIMEOUT) begin tmo_exp = 1'b1; fin = 1'b1; end
        else if (k == b + 1) st = 1'b1;
      end else if (periph_done) begin
        fin = 1'b1;
      end else if (k == TIMEOUT) begin
        tmo_exp = 1'b1; fin = 1'b1;
      end
      chk($sformatf("%s.k%0d", name, k), get_obs(), eo(2 + k, 15'h0, st, 1'b0));
      if (fin) break;
    end
    periph_busy = 1'b0; periph_done = 1'b0;
  endtask

  initial begin
    int          n;
    logic [14:0] s0, s1, s2;
    logic [3:0]  op;
    bit          c, z;

    vt[0]  = mkv(4'h1, 0, 0, 2, ms(6, 0, S_MEM), ms(5, 0, S_RA), 15'h0);
    vt[1]  = mkv(4'h3, 0, 0, 3, ms(6, 0, S_MEM), ms(5, 0, S_RB | S_FL), ms(3, 1, S_RA));
    vt[2]  = mkv(4'h7, 0, 1, 1, 15'h0, 15'h0, 15'h0);
    vt[3]  = mkv(4'h7, 1, 0, 1, ms(6, 0, S_PC), 15'h0, 15'h0);
    vt[4]  = mkv(4'h2, 1, 1, 3, ms(6, 0, S_MEM), ms(5, 0, S_RB | S_FL), ms(3, 0, S_RA));
    vt[5]  = mkv(4'h8, 0, 1, 1, ms(6, 0, S_PC), 15'h0, 15'h0);
    vt[6]  = mkv(4'h8, 1, 0, 1, 15'h0, 15'h0, 15'h0);
    vt[7]  = mkv(4'h4, 0, 0, 2, ms(6, 0, S_MEM), ms(2, 0, S_RAM), 15'h0);
    vt[8]  = mkv(4'h5, 0, 0, 1, ms(6, 0, S_RA), 15'h0, 15'h0);
    vt[9]  = mkv(4'h6, 0, 0, 1, ms(6, 0, S_PC), 15'h0, 15'h0);
    vt[10] = mkv(4'h9, 0, 0, 2, ms(6, 0, S_MEM), ms(3, 2, S_RA | S_FL), 15'h0);
    vt[11] = mkv(4'hA, 0, 0, 2, ms(6, 0, S_MEM), ms(3, 3, S_RA | S_FL), 15'h0);
    vt[12] = mkv(4'hE, 0, 0, 1, ms(2, 0, S_OUT), 15'h0, 15'h0);
    vt[13] = mkv(4'h0, 1, 1, 1, 15'h0, 15'h0, 15'h0);
    vt[14] = mkv(4'hC, 0, 0, 1, 15'h0, 15'h0, 15'h0);

    #2;
    do_reset();

    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].op, vt[i].c, vt[i].z, vt[i].n, vt[i].s0, vt[i].s1, vt[i].s2,
             $sformatf("vec%0d_op%h", i, vt[i].op));
    end

    // Handshake corner cases: busy then done, done exactly at expiry, no done at all.
    do_reset();
    run_mrs(3, 5, "mrs_busy3_done5");
    run_mrs(0, TIMEOUT - 1, "mrs_done_at_expiry");
    run_mrs(0, 0, "mrs_timeout");
    run_op(4'h1, 0, 0, 2, ms(6, 0, S_MEM), ms(5, 0, S_RA), 15'h0, "lda_after_timeout");
    run_mrs(TIMEOUT + 4, 0, "mrs_stall_timeout");

    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 14));
      c = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      if (op == 4'hB) begin
        run_mrs(int'($urandom_range(0, 6)), int'($urandom_range(0, 30)), $sformatf("rnd%0d_mrs", i));
      end else begin
        model(op, c, z, n, s0, s1, s2);
        run_op(op, c, z, n, s0, s1, s2, $sformatf("rnd%0d_op%h", i, op));
      end
    end

    // Wider opcode: nonzero upper bits make an otherwise valid LDA illegal.
    instruction = 4'h0;
    instr6 = 6'b010001;
    do_reset();
    tick();
    chk("w6.f0", get_obs6(), mk(0, 0, 0, 0, 0, ms(1, 0, S_MEM)));
    tick();
    chk("w6.f1", get_obs6(), mk(0, 0, 0, 0, 1, ms(5, 0, S_IR | S_APC)));
    tick();
    chk("w6.s2", get_obs6(), mk(0, 1, 0, 0, 2, 15'h0));
    tick();
    chk("w6.next_f0", get_obs6(), mk(0, 1, 0, 0, 0, ms(1, 0, S_MEM)));

    // Halt is sticky across opcode/flag changes; async reset clears it.
    do_reset();
    instruction = 4'hF;
    run_fetch("hlt");
    tick();
    chk("hlt.s2", get_obs(), eo(2, 15'h0, 1'b0, 1'b1));
    for (int i = 0; i < 10; i++) begin
      instruction = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag = 1'($urandom_range(0, 1));
      tick();
      chk($sformatf("hlt.hold%0d", i), get_obs(), eo(3 + i, 15'h0, 1'b0, 1'b1));
    end
    #1;
    do_reset();
    run_op(4'h1, 0, 0, 2, ms(6, 0, S_MEM), ms(5, 0, S_RA), 15'h0, "lda_after_hlt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
